ex_muldiv: RTL and testbench

//  Iterative RV64M multiply/divide unit in the EX stage, fed by the ID/EX register's data1/data2 and alu_ops M-flags.

---
 rtl/ex_muldiv.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV64M multiply/divide unit for the EX stage.
// One product or quotient bit per cycle on operand magnitudes, with sign
// correction on the final step. Divide-by-zero and signed overflow
// finish in one cycle.
module ex_muldiv #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic            hold,
  input  logic            mul_op,
  input  logic            mulh_op,
  input  logic            mulhsu_op,
  input  logic            div_op,
  input  logic            rem_op,
  input  logic            is_unsign,
  input  logic            is_word,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned WLEN  = 32;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  counter;
  logic [XLEN-1:0]   opb;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   hi;       // product high half / partial remainder
  logic [XLEN-1:0]   mq;       // multiplier shifting out / dividend-quotient
  logic              op_mul;
  logic              op_mulh;
  logic              op_div;
  logic              op_rem;
  logic              word_r;
  logic              neg_r;

  // Operand preparation and single-cycle corner detection
  logic [WLEN-1:0]   a_lo;
  logic [WLEN-1:0]   b_lo;
  logic              any_div;
  logic              sgn1;
  logic              sgn2;
  logic              a_sgn;
  logic              b_sgn;
  logic [XLEN-1:0]   a_ext;
  logic [XLEN-1:0]   b_ext;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   a_sext;
  logic              div_zero;
  logic              div_ovf;
  logic              corner;
  logic              res_neg;
  logic [XLEN-1:0]   corner_res;

  // Decode signedness, build magnitudes and resolve div-by-zero/overflow
  always_comb begin
    a_lo       = data1[WLEN-1:0];
    b_lo       = data2[WLEN-1:0];
    any_div    = div_op | rem_op;
    sgn1       = ~is_unsign & (mulh_op | mulhsu_op | any_div);
    sgn2       = ~is_unsign & (mulh_op | any_div);
    a_sgn      = sgn1 & (is_word ? a_lo[WLEN-1] : data1[XLEN-1]);
    b_sgn      = sgn2 & (is_word ? b_lo[WLEN-1] : data2[XLEN-1]);
    a_ext      = is_word ? {32'd0, a_lo} : data1;
    b_ext      = is_word ? {32'd0, b_lo} : data2;
    a_sext     = {{32{a_lo[WLEN-1]}}, a_lo};
    a_mag      = a_ext;
    b_mag      = b_ext;
    if (a_sgn) a_mag = is_word ? {32'd0, ~a_lo + 32'd1} : ~data1 + 64'd1;
    if (b_sgn) b_mag = is_word ? {32'd0, ~b_lo + 32'd1} : ~data2 + 64'd1;
    div_zero   = any_div & (b_ext == 64'd0);
    div_ovf    = any_div & ~is_unsign &
                 (is_word ? ((a_lo == 32'h8000_0000) && (b_lo == 32'hFFFF_FFFF))
                          : ((data1 == 64'h8000_0000_0000_0000) && (data2 == 64'hFFFF_FFFF_FFFF_FFFF)));
    corner     = div_zero | div_ovf;
    res_neg    = 1'b0;
    if (mulh_op)   res_neg = a_sgn ^ b_sgn;
    if (mulhsu_op) res_neg = a_sgn;
    if (div_op)    res_neg = a_sgn ^ b_sgn;
    if (rem_op)    res_neg = a_sgn;
    corner_res = 64'd0;
    if (div_zero) begin
      if (div_op) corner_res = 64'hFFFF_FFFF_FFFF_FFFF;
      else        corner_res = is_word ? a_sext : data1;
    end else if (div_ovf) begin
      if (div_op) corner_res = is_word ? a_sext : data1;
    end
  end

  // One iteration step plus final sign correction
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   hi_nxt;
  logic [XLEN-1:0]   mq_nxt;
  logic [XLEN-1:0]   hi_fix;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   calc_res;

  // Shift-add for multiply, restoring subtract for divide
  always_comb begin
    mul_sum  = {1'b0, hi} + (mq[0] ? {1'b0, opb} : 65'd0);
    rem_sh   = {hi, mq[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb};
    q_bit    = ~rem_diff[XLEN];
    if (op_div | op_rem) begin
      hi_nxt = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      mq_nxt = {mq[XLEN-2:0], q_bit};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      mq_nxt = {mul_sum[0], mq[XLEN-1:1]};
    end
    // High half of a 128-bit two's complement negate: carry in only when low half is zero
    hi_fix   = neg_r ? (~hi_nxt + {63'd0, (mq_nxt == 64'd0)}) : hi_nxt;
    quo      = word_r ? {32'd0, mq_nxt[WLEN-1:0]} : mq_nxt;
    quo_fix  = neg_r ? (~quo + 64'd1) : quo;
    rem_fix  = neg_r ? (~hi_nxt + 64'd1) : hi_nxt;
    if (op_mul)       calc_res = word_r ? {{32{mq_nxt[XLEN-1]}}, mq_nxt[XLEN-1:WLEN]} : mq_nxt;
    else if (op_mulh) calc_res = hi_fix;
    else if (op_div)  calc_res = word_r ? {{32{quo_fix[WLEN-1]}}, quo_fix[WLEN-1:0]} : quo_fix;
    else              calc_res = word_r ? {{32{rem_fix[WLEN-1]}}, rem_fix[WLEN-1:0]} : rem_fix;
  end

  // Stall the front of the pipe while an op is accepted or iterating
  assign stall_req = ~rst & (((state == IDLE) & start & ~flush) | (state == CALC));

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
      opb     <= '0;
      hi      <= '0;
      mq      <= '0;
      op_mul  <= 1'b0;
      op_mulh <= 1'b0;
      op_div  <= 1'b0;
      op_rem  <= 1'b0;
      word_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      done    <= 1'b0;
      counter <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_mul  <= mul_op;
            op_mulh <= mulh_op | mulhsu_op;
            op_div  <= div_op;
            op_rem  <= rem_op;
            word_r  <= is_word;
            neg_r   <= res_neg;
            hi      <= '0;
            opb     <= any_div ? b_mag : a_mag;
            mq      <= any_div ? (is_word ? {a_mag[WLEN-1:0], 32'd0} : a_mag) : b_mag;
            if (corner) begin
              result  <= corner_res;
              done    <= 1'b1;
              counter <= '0;
              state   <= DONE;
            end else begin
              counter <= is_word ? CNT_W'(WLEN) : CNT_W'(XLEN);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          hi      <= hi_nxt;
          mq      <= mq_nxt;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            result <= calc_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          if (!hold) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table plus flush/hold/reset sequences.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        hold;
  logic        mul_op;
  logic        mulh_op;
  logic        mulhsu_op;
  logic        div_op;
  logic        rem_op;
  logic        is_unsign;
  logic        is_word;
  logic [63:0] data1;
  logic [63:0] data2;
  logic        stall_req;
  logic        done;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2,
                         OP_DIV = 3'd3, OP_REM = 3'd4;

  typedef struct {
    logic [2:0]  op;
    logic        uns;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .hold(hold),
    .mul_op(mul_op), .mulh_op(mulh_op), .mulhsu_op(mulhsu_op),
    .div_op(div_op), .rem_op(rem_op), .is_unsign(is_unsign), .is_word(is_word),
    .data1(data1), .data2(data2), .stall_req(stall_req), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Exactly one op flag must accompany start
  always @(posedge clk) begin
    if (!rst && start)
      assert ($onehot({mul_op, mulh_op, mulhsu_op, div_op, rem_op}))
        else $error("illegal op flag combination with start");
  end

  function automatic vec_t mk(input logic [2:0] op, input logic uns, input logic word,
                              input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] exp, input int lat);
    vec_t v;
    v.op = op; v.uns = uns; v.word = word; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_op(input vec_t v);
    mul_op    = (v.op == OP_MUL);
    mulh_op   = (v.op == OP_MULH);
    mulhsu_op = (v.op == OP_MULHSU);
    div_op    = (v.op == OP_DIV);
    rem_op    = (v.op == OP_REM);
    is_unsign = v.uns;
    is_word   = v.word;
    data1     = v.a;
    data2     = v.b;
  endtask

  task automatic clr_op();
    mul_op = 1'b0; mulh_op = 1'b0; mulhsu_op = 1'b0; div_op = 1'b0; rem_op = 1'b0;
    is_unsign = 1'b0; is_word = 1'b0; data1 = '0; data2 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at cycle 0 and check latency, result and handshake
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    set_op(v);
    start = 1'b1;
    #1;
    chkint($sformatf("v%0d_stall_c0", idx), int'(stall_req), 1);
    tick();
    start = 1'b0;
    clr_op();
    cyc = 1;
    while (!done && cyc < 100) begin
      if (stall_req !== 1'b1)
        chkint($sformatf("v%0d_stall_c%0d", idx, cyc), int'(stall_req), 1);
      tick();
      cyc++;
    end
    chkint($sformatf("v%0d_latency", idx), cyc, v.lat);
    chk64($sformatf("v%0d_result", idx), result, v.exp);
    chkint($sformatf("v%0d_stall_done", idx), int'(stall_req), 0);
    tick();
    chkint($sformatf("v%0d_done_clear", idx), int'(done), 0);
  endtask

  initial begin
    logic [63:0] last_res;
    int          done_seen;

    vecs[0]  = mk(OP_MUL,    1'b0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    vecs[1]  = mk(OP_MULH,   1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    vecs[2]  = mk(OP_MULH,   1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'h1, 65);
    vecs[3]  = mk(OP_MULHSU, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    vecs[4]  = mk(OP_DIV,    1'b0, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    vecs[5]  = mk(OP_REM,    1'b1, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    vecs[6]  = mk(OP_DIV,    1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    vecs[7]  = mk(OP_REM,    1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    vecs[8]  = mk(OP_DIV,    1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    vecs[9]  = mk(OP_REM,    1'b0, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    vecs[10] = mk(OP_MUL,    1'b0, 1'b1, 64'h1_0000_0003, 64'hFFFF_FFFF_0000_0005, 64'hF, 33);
    vecs[11] = mk(OP_MUL,    1'b0, 1'b1, 64'h0001_0000, 64'h0001_8000, 64'hFFFF_FFFF_8000_0000, 33);
    vecs[12] = mk(OP_DIV,    1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    vecs[13] = mk(OP_REM,    1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    vecs[14] = mk(OP_DIV,    1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    vecs[15] = mk(OP_REM,    1'b1, 1'b0, 64'd100, 64'd7, 64'd2, 65);
    vecs[16] = mk(OP_DIV,    1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h10, 64'h0000_0000_0800_0000, 33);
    vecs[17] = mk(OP_DIV,    1'b0, 1'b1, 64'd5, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    vecs[18] = mk(OP_REM,    1'b0, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1);
    vecs[19] = mk(OP_DIV,    1'b0, 1'b1, 64'hAAAA_AAAA_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    vecs[20] = mk(OP_MULH,   1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    vecs[21] = mk(OP_REM,    1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 65);

    rst = 1'b1; start = 1'b0; flush = 1'b0; hold = 1'b0;
    clr_op();
    tick();
    tick();
    chkint("reset_done", int'(done), 0);
    chk64("reset_result", result, 64'd0);
    chkint("reset_stall", int'(stall_req), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);
    last_res = vecs[NV-1].exp;

    // flush overrides start while idle
    set_op(vecs[0]);
    start = 1'b1;
    flush = 1'b1;
    #1;
    chkint("idle_flush_stall", int'(stall_req), 0);
    tick();
    start = 1'b0; flush = 1'b0; clr_op();
    chkint("idle_flush_done", int'(done), 0);
    chkint("idle_flush_stall_after", int'(stall_req), 0);

    // flush MUL at cycle 10
    set_op(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0; clr_op();
    for (int c = 1; c < 10; c++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chkint("flush_stall_c11", int'(stall_req), 0);
    done_seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (done) done_seen++;
      tick();
    end
    chkint("flush_no_done", done_seen, 0);
    chk64("flush_result_kept", result, last_res);

    // hold in DONE for three cycles
    set_op(vecs[4]);
    start = 1'b1;
    hold = 1'b1;
    tick();
    start = 1'b0; clr_op();
    for (int c = 1; c <= 3; c++) begin
      chkint($sformatf("hold_done_c%0d", c), int'(done), 1);
      chk64($sformatf("hold_result_c%0d", c), result, 64'hFFFF_FFFF_FFFF_FFFF);
      chkint($sformatf("hold_stall_c%0d", c), int'(stall_req), 0);
      if (c == 3) hold = 1'b0;
      tick();
    end
    chkint("hold_release_done", int'(done), 0);
    chk64("hold_release_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

    // reset at cycle 20 of MUL
    set_op(vecs[0]);
    start = 1'b1;
    tick();
    start = 1'b0; clr_op();
    for (int c = 1; c < 20; c++) tick();
    chkint("rst_pre_stall", int'(stall_req), 1);
    rst = 1'b1;
    tick();
    chkint("rst_done", int'(done), 0);
    chk64("rst_result", result, 64'd0);
    chkint("rst_stall", int'(stall_req), 0);
    rst = 1'b0;
    tick();
    chkint("rst_idle_stall", int'(stall_req), 0);
    done_seen = 0;
    for (int c = 0; c < 70; c++) begin
      if (done) done_seen++;
      tick();
    end
    chkint("rst_no_done", done_seen, 0);

    run_vec(vecs[0], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
